// File: rtl/wb_rf_pkg.sv
`default_nettype none
// =============================================================================
// wb_rf_pkg : shared sizes and types for the writeback register file
// Rev 1.0
// =============================================================================
package wb_rf_pkg;

   localparam int DATA_W   = 24;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam int CNT_W    = 2;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] reg_data_t;
   typedef logic [CNT_W-1:0]  pend_cnt_t;

   localparam pend_cnt_t CNT_MAX  = '1;
   localparam reg_idx_t  ZERO_REG = '0;

endpackage : wb_rf_pkg
`default_nettype wire

// File: rtl/wb_pending_counter.sv
`default_nettype none
// =============================================================================
// wb_pending_counter : saturating in-flight write counter for one register
// Rev 1.0
// =============================================================================
module wb_pending_counter
   import wb_rf_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      i_inc,
   input  logic      i_dec,
   input  logic      i_clr,
   output pend_cnt_t o_cnt,
   output logic      o_ovf,
   output logic      o_unf
);

   pend_cnt_t r_cnt;
   logic      w_up;
   logic      w_down;

   // Coincident issue and writeback cancel; a clear swallows both.
   assign w_up   = !i_clr && i_inc && !i_dec;
   assign w_down = !i_clr && i_dec && !i_inc;

   assign o_ovf = w_up   && (r_cnt == CNT_MAX);
   assign o_unf = w_down && (r_cnt == '0);
   assign o_cnt = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (w_up && !o_ovf) begin
         r_cnt <= r_cnt + pend_cnt_t'(1);
      end else if (w_down && !o_unf) begin
         r_cnt <= r_cnt - pend_cnt_t'(1);
      end
   end

endmodule : wb_pending_counter
`default_nettype wire

// File: rtl/wb_register_file.sv
`default_nettype none
// =============================================================================
// wb_register_file : 16x24 writeback register file, two bypassed read ports,
//                    per-register pending scoreboard and decode hazard stall
// Rev 1.0
// =============================================================================
module wb_register_file
   import wb_rf_pkg::*;
#(
   parameter bit ZERO_REG_EN = 1'b1
)
(
   input  logic                clk_a,
   input  logic                rst,
   input  logic                wb_enable,
   input  reg_idx_t            wb_dest,
   input  reg_data_t           wb_data,
   input  reg_idx_t            rd_addr_a,
   input  reg_idx_t            rd_addr_b,
   output reg_data_t           rd_data_a,
   output reg_data_t           rd_data_b,
   input  logic                issue_valid,
   input  reg_idx_t            issue_dest,
   input  logic                flush,
   output logic                hazard_stall,
   output logic [NUM_REGS-1:0] pending_vec,
   output logic [1:0]          err_sticky
);

   reg_data_t           r_mem [NUM_REGS];
   logic [1:0]          r_err;

   pend_cnt_t           w_cnt  [NUM_REGS];
   logic [NUM_REGS-1:0] w_inc;
   logic [NUM_REGS-1:0] w_dec;
   logic [NUM_REGS-1:0] w_nz;
   logic [NUM_REGS-1:0] w_pend;
   logic [NUM_REGS-1:0] w_ovf;
   logic [NUM_REGS-1:0] w_unf;
   logic                w_wr_en;
   logic                w_zero_a;
   logic                w_zero_b;
   logic                w_byp_a;
   logic                w_byp_b;

   assign w_wr_en = wb_enable && !(ZERO_REG_EN && (wb_dest == ZERO_REG));

   always_ff @(posedge clk_a or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[wb_dest] <= wb_data;
      end
   end

   // Bypass is suppressed while in reset so reads show the cleared file.
   assign w_zero_a = ZERO_REG_EN && (rd_addr_a == ZERO_REG);
   assign w_zero_b = ZERO_REG_EN && (rd_addr_b == ZERO_REG);
   assign w_byp_a  = rst && w_wr_en && (wb_dest == rd_addr_a);
   assign w_byp_b  = rst && w_wr_en && (wb_dest == rd_addr_b);

   assign rd_data_a = w_zero_a ? '0 : (w_byp_a ? wb_data : r_mem[rd_addr_a]);
   assign rd_data_b = w_zero_b ? '0 : (w_byp_b ? wb_data : r_mem[rd_addr_b]);

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
      localparam bit c_IS_ZERO = ZERO_REG_EN && (reg_idx_t'(g) == ZERO_REG);

      assign w_inc[g] = issue_valid && (issue_dest == reg_idx_t'(g)) && !c_IS_ZERO;
      assign w_dec[g] = wb_enable   && (wb_dest    == reg_idx_t'(g)) && !c_IS_ZERO;

      wb_pending_counter u_cnt (
         .clk   (clk_a),
         .rst_n (rst),
         .i_inc (w_inc[g]),
         .i_dec (w_dec[g]),
         .i_clr (flush),
         .o_cnt (w_cnt[g]),
         .o_ovf (w_ovf[g]),
         .o_unf (w_unf[g])
      );

      assign w_nz[g] = (w_cnt[g] != '0);
      // The last outstanding write landing this cycle is already bypassed.
      assign w_pend[g] = w_nz[g] && !((w_cnt[g] == pend_cnt_t'(1)) && w_dec[g]);
   end

   assign hazard_stall = rst && (w_pend[rd_addr_a] || w_pend[rd_addr_b]);
   assign pending_vec  = w_nz;

   always_ff @(posedge clk_a or negedge rst) begin
      if (!rst) begin
         r_err <= '0;
      end else begin
         r_err <= r_err | {(|w_unf), (|w_ovf)};
      end
   end

   assign err_sticky = r_err;

endmodule : wb_register_file
`default_nettype wire

// File: tb/tb_wb_register_file.sv
`default_nettype none
// =============================================================================
// tb_wb_register_file : directed table, corner sequences and randomized run
//                       against a behavioural register-file model
// Rev 1.0
// =============================================================================
module tb_wb_register_file;

   logic        clk_a = 1'b0;
   logic        rst;
   logic        wb_enable;
   logic [3:0]  wb_dest;
   logic [23:0] wb_data;
   logic [3:0]  rd_addr_a;
   logic [3:0]  rd_addr_b;
   logic [23:0] rd_data_a;
   logic [23:0] rd_data_b;
   logic        issue_valid;
   logic [3:0]  issue_dest;
   logic        flush;
   logic        hazard_stall;
   logic [15:0] pending_vec;
   logic [1:0]  err_sticky;

   always #5 clk_a = ~clk_a;

   wb_register_file dut (
      .clk_a        (clk_a),
      .rst          (rst),
      .wb_enable    (wb_enable),
      .wb_dest      (wb_dest),
      .wb_data      (wb_data),
      .rd_addr_a    (rd_addr_a),
      .rd_addr_b    (rd_addr_b),
      .rd_data_a    (rd_data_a),
      .rd_data_b    (rd_data_b),
      .issue_valid  (issue_valid),
      .issue_dest   (issue_dest),
      .flush        (flush),
      .hazard_stall (hazard_stall),
      .pending_vec  (pending_vec),
      .err_sticky   (err_sticky)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: plain arrays and integer counts.
   logic [23:0] m_mem [16];
   int          m_cnt [16];
   logic [1:0]  m_err;

   typedef struct {
      logic        we;
      logic [3:0]  wd;
      logic [23:0] wdat;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic        iv;
      logic [3:0]  id;
      logic        fl;
      logic [23:0] ea;
      logic [23:0] eb;
      logic        es;
      logic [15:0] ep;
      logic [1:0]  ee;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_mem[i] = '0;
         m_cnt[i] = 0;
      end
      m_err = '0;
   endtask

   function automatic logic [23:0] m_read(input logic [3:0] a);
      if (a == 0) return '0;
      if (wb_enable && wb_dest == a) return wb_data;
      return m_mem[a];
   endfunction

   function automatic logic m_pend(input logic [3:0] r);
      if (m_cnt[r] == 0) return 1'b0;
      return !(m_cnt[r] == 1 && wb_enable && wb_dest == r);
   endfunction

   function automatic logic [15:0] m_pvec();
      logic [15:0] v;
      for (int i = 0; i < 16; i++) v[i] = (m_cnt[i] != 0);
      return v;
   endfunction

   // Apply the architectural effect of the current inputs at the next edge.
   task automatic m_edge();
      if (wb_enable && wb_dest != 0) m_mem[wb_dest] = wb_data;
      for (int r = 1; r < 16; r++) begin
         bit inc, dec;
         inc = issue_valid && issue_dest == r;
         dec = wb_enable && wb_dest == r;
         if (flush) begin
            m_cnt[r] = 0;
         end else if (inc && !dec) begin
            if (m_cnt[r] == 3) m_err[0] = 1'b1;
            else m_cnt[r] = m_cnt[r] + 1;
         end else if (dec && !inc) begin
            if (m_cnt[r] == 0) m_err[1] = 1'b1;
            else m_cnt[r] = m_cnt[r] - 1;
         end
      end
   endtask

   task automatic tick();
      m_edge();
      @(posedge clk_a);
      #1;
   endtask

   task automatic idle();
      wb_enable = 0; wb_dest = 0; wb_data = 0;
      issue_valid = 0; issue_dest = 0; flush = 0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".rd_a"},  rd_data_a,    m_read(rd_addr_a));
      chk({tag, ".rd_b"},  rd_data_b,    m_read(rd_addr_b));
      chk({tag, ".stall"}, hazard_stall, m_pend(rd_addr_a) || m_pend(rd_addr_b));
      chk({tag, ".pend"},  pending_vec,  m_pvec());
      chk({tag, ".err"},   err_sticky,   m_err);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      m_reset();
      @(negedge clk_a);
      @(negedge clk_a);
      rst = 1'b1;
      @(posedge clk_a);
      #1;
   endtask

   initial begin
      idle();
      rd_addr_a = 0; rd_addr_b = 0;
      rst = 1'b0;
      m_reset();
      #2;
      chk("reset.rd_a", rd_data_a, 24'h0);
      chk("reset.pend", pending_vec, 16'h0);
      chk("reset.stall", hazard_stall, 1'b0);
      chk("reset.err", err_sticky, 2'b00);
      do_reset();

      //           we wd  wdat        ra rb iv id fl  ea          eb          es ep        ee
      tbl[0]  = '{1, 5, 24'hABCDEF, 5, 0, 0, 0, 0, 24'hABCDEF, 24'h0,      0, 16'h0000, 2'b00};
      tbl[1]  = '{0, 0, 24'h0,      5, 0, 1, 3, 0, 24'hABCDEF, 24'h0,      0, 16'h0000, 2'b10};
      tbl[2]  = '{0, 0, 24'h0,      0, 3, 0, 0, 0, 24'h0,      24'h0,      1, 16'h0008, 2'b10};
      tbl[3]  = '{1, 3, 24'h000007, 0, 3, 0, 0, 0, 24'h0,      24'h000007, 0, 16'h0008, 2'b10};
      tbl[4]  = '{0, 0, 24'h0,      0, 3, 0, 0, 0, 24'h0,      24'h000007, 0, 16'h0000, 2'b10};
      tbl[5]  = '{0, 0, 24'h0,      0, 0, 1, 4, 0, 24'h0,      24'h0,      0, 16'h0000, 2'b10};
      tbl[6]  = '{1, 4, 24'h111111, 4, 0, 1, 4, 0, 24'h111111, 24'h0,      0, 16'h0010, 2'b10};
      tbl[7]  = '{0, 0, 24'h0,      4, 0, 0, 0, 0, 24'h111111, 24'h0,      1, 16'h0010, 2'b10};
      tbl[8]  = '{0, 0, 24'h0,      4, 0, 1, 6, 1, 24'h111111, 24'h0,      1, 16'h0010, 2'b10};
      tbl[9]  = '{0, 0, 24'h0,      4, 6, 0, 0, 0, 24'h111111, 24'h0,      0, 16'h0000, 2'b10};
      tbl[10] = '{1, 0, 24'h123456, 0, 0, 0, 0, 0, 24'h0,      24'h0,      0, 16'h0000, 2'b10};
      tbl[11] = '{0, 0, 24'h0,      0, 5, 0, 0, 0, 24'h0,      24'hABCDEF, 0, 16'h0000, 2'b10};

      for (int i = 0; i < 12; i++) begin
         wb_enable = tbl[i].we; wb_dest = tbl[i].wd; wb_data = tbl[i].wdat;
         rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
         issue_valid = tbl[i].iv; issue_dest = tbl[i].id; flush = tbl[i].fl;
         #1;
         chk($sformatf("tbl%0d.rd_a", i),  rd_data_a,    tbl[i].ea);
         chk($sformatf("tbl%0d.rd_b", i),  rd_data_b,    tbl[i].eb);
         chk($sformatf("tbl%0d.stall", i), hazard_stall, tbl[i].es);
         chk($sformatf("tbl%0d.pend", i),  pending_vec,  tbl[i].ep);
         chk($sformatf("tbl%0d.err", i),   err_sticky,   tbl[i].ee);
         tick();
      end

      // Asynchronous reset in the middle of a cycle with live state.
      idle();
      wb_enable = 1; wb_dest = 9; wb_data = 24'h55AA55;
      tick();
      idle();
      issue_valid = 1; issue_dest = 9;
      tick();
      idle();
      rd_addr_a = 9; rd_addr_b = 9;
      #1;
      chk("prerst.stall", hazard_stall, 1'b1);
      chk("prerst.rd_a", rd_data_a, 24'h55AA55);
      rst = 1'b0;
      m_reset();
      #1;
      chk("asyncrst.rd_a", rd_data_a, 24'h0);
      chk("asyncrst.rd_b", rd_data_b, 24'h0);
      chk("asyncrst.pend", pending_vec, 16'h0);
      chk("asyncrst.stall", hazard_stall, 1'b0);
      chk("asyncrst.err", err_sticky, 2'b00);
      @(negedge clk_a);
      rst = 1'b1;
      @(posedge clk_a);
      #1;

      // Overflow then underflow on register 2.
      idle();
      rd_addr_a = 2; rd_addr_b = 0;
      for (int k = 0; k < 4; k++) begin
         issue_valid = 1; issue_dest = 2;
         tick();
      end
      idle();
      #1;
      chk("ovf.err", err_sticky, 2'b01);
      chk("ovf.pend", pending_vec, 16'h0004);
      chk("ovf.stall", hazard_stall, 1'b1);
      for (int k = 0; k < 3; k++) begin
         wb_enable = 1; wb_dest = 2; wb_data = 24'h000100 + 24'(k);
         tick();
      end
      idle();
      #1;
      chk("drain.pend", pending_vec, 16'h0000);
      chk("drain.err", err_sticky, 2'b01);
      chk("drain.rd_a", rd_data_a, 24'h000102);
      wb_enable = 1; wb_dest = 2; wb_data = 24'hFEDCBA;
      tick();
      idle();
      #1;
      chk("unf.err", err_sticky, 2'b11);
      chk("unf.rd_a", rd_data_a, 24'hFEDCBA);

      // Randomized run against the model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         wb_enable   = ($urandom_range(0, 1) == 1);
         wb_dest     = 4'($urandom_range(1, 15));
         wb_data     = 24'($urandom);
         rd_addr_a   = 4'($urandom_range(0, 15));
         rd_addr_b   = 4'($urandom_range(0, 15));
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_dest  = 4'($urandom_range(0, 15));
         flush       = ($urandom_range(0, 15) == 0);
         #1;
         check_model("rnd");
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_wb_register_file
`default_nettype wire
